// File: rtl/array_mul_sequencer_if.sv
// Operand, datapath and result signals of the array multiplier sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface array_mul_sequencer_if #(
    parameter int WIDTH        = 16,
    parameter int RESULT_WIDTH = 32
);
    logic                    src_valid;
    logic                    src_ready;
    logic [WIDTH-1:0]        src_multiplier;
    logic [WIDTH-1:0]        src_multiplicand;

    logic                    dp_start_tx;
    logic                    dp_counted_15;
    logic [WIDTH-1:0]        dp_multiplier;
    logic [WIDTH-1:0]        dp_multiplicand;
    logic                    dp_get_output;
    logic [RESULT_WIDTH-1:0] dp_product;

    logic                    dst_valid;
    logic                    dst_ready;
    logic [RESULT_WIDTH-1:0] dst_product;
    logic                    dst_err;

    modport slave (
        input  src_valid, src_multiplier, src_multiplicand,
        input  dp_get_output, dp_product, dst_ready,
        output src_ready, dp_start_tx, dp_counted_15, dp_multiplier, dp_multiplicand,
        output dst_valid, dst_product, dst_err
    );

    modport master (
        output src_valid, src_multiplier, src_multiplicand,
        output dp_get_output, dp_product, dst_ready,
        input  src_ready, dp_start_tx, dp_counted_15, dp_multiplier, dp_multiplicand,
        input  dst_valid, dst_product, dst_err
    );
endinterface

// File: rtl/array_mul_sequencer.sv
// Sequencer for the serial array multiplier: accepts an operand pair, steps the
// datapath WIDTH times, waits (bounded) for the product and hands it downstream.
module array_mul_sequencer #(
    parameter int WIDTH        = 16,
    parameter int RESULT_WIDTH = 32,
    parameter int TIMEOUT      = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    array_mul_sequencer_if.slave bus,
    output logic                 busy,
    output logic                 seq_err,
    output logic [CNT_W-1:0]     op_count
);
    localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);
    localparam logic [TO_W-1:0]   LAST_WAIT = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [TO_W-1:0]         to_q, to_d;
    logic [WIDTH-1:0]        mult_q, mult_d;
    logic [WIDTH-1:0]        mcand_q, mcand_d;
    logic [RESULT_WIDTH-1:0] prod_q, prod_d;
    logic                    err_q, err_d;
    logic                    seq_err_q, seq_err_d;
    logic [CNT_W-1:0]        op_q, op_d;

    // NOTE: every register, including the operand and product holding registers,
    // is cleared by reset so an aborted operation leaves no stale data visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            to_q      <= '0;
            mult_q    <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            err_q     <= 1'b0;
            seq_err_q <= 1'b0;
            op_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge state.
            state_q   <= state_d;
            step_q    <= step_d;
            to_q      <= to_d;
            mult_q    <= mult_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            err_q     <= err_d;
            seq_err_q <= seq_err_d;
            op_q      <= op_d;
        end
    end

    // NOTE: all next-state values take their hold value first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        to_d      = to_q;
        mult_d    = mult_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        err_d     = err_q;
        op_d      = op_q;
        seq_err_d = seq_err_q | (bus.dp_get_output && (state_q != S_WAIT));

        unique case (state_q)
            S_IDLE: begin
                if (bus.src_valid) begin
                    mult_d  = bus.src_multiplier;
                    mcand_d = bus.src_multiplicand;
                    step_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    to_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A product arriving in the last allowed cycle still wins over the timeout.
                if (bus.dp_get_output) begin
                    prod_d  = bus.dp_product;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (to_q == LAST_WAIT) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_DONE: begin
                if (bus.dst_ready) begin
                    op_d    = op_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.src_ready       = (state_q == S_IDLE);
    assign bus.dp_start_tx     = (state_q == S_RUN);
    assign bus.dp_counted_15   = (state_q == S_RUN) && (step_q == LAST_STEP);
    assign bus.dp_multiplier   = mult_q;
    assign bus.dp_multiplicand = mcand_q;
    assign bus.dst_valid       = (state_q == S_DONE);
    assign bus.dst_product     = prod_q;
    assign bus.dst_err         = err_q;
    assign busy                = (state_q != S_IDLE);
    assign seq_err             = seq_err_q;
    assign op_count            = op_q;
endmodule

// File: tb/tb_array_mul_sequencer.sv
// Randomised scoreboard bench for array_mul_sequencer with a behavioural datapath.
module tb_array_mul_sequencer;
    localparam int WIDTH   = 16;
    localparam int RW      = 32;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [RW-1:0] prod;
        logic          err;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             busy;
    logic             seq_err;
    logic [CNT_W-1:0] op_count;
    logic             dp_go_model;
    logic             dp_go_inject;
    bit               dp_mode_timeout;

    exp_t sb_q[$];
    int   tests;
    int   fails;
    int   exp_ops;

    array_mul_sequencer_if #(.WIDTH(WIDTH), .RESULT_WIDTH(RW)) bus ();

    array_mul_sequencer #(
        .WIDTH(WIDTH), .RESULT_WIDTH(RW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .seq_err(seq_err),
        .op_count(op_count)
    );

    assign bus.dp_get_output = dp_go_model | dp_go_inject;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return RW'(sa * sb);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Datapath model: one cycle after the final step it returns the signed product.
    initial begin
        dp_go_model    = 1'b0;
        bus.dp_product = '0;
        forever begin
            @(negedge clk);
            if (bus.dp_counted_15 && !dp_mode_timeout) begin
                @(posedge clk);
                #1;
                dp_go_model    = 1'b1;
                bus.dp_product = ref_mul(bus.dp_multiplier, bus.dp_multiplicand);
                @(posedge clk);
                #1;
                dp_go_model    = 1'b0;
                bus.dp_product = $urandom;
            end
        end
    end

    // Monitor: pops an expectation on every completed result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.dst_valid && bus.dst_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("dst_product", bus.dst_product, e.prod);
                    check("dst_err", bus.dst_err, e.err);
                end
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit timeout_mode, input int hold);
        int   k;
        int   start_n;
        int   c15_n;
        int   c15_k;
        int   kv;
        int   unstable;
        logic [RW-1:0] held;
        exp_t e;

        dp_mode_timeout = timeout_mode;
        e.prod = timeout_mode ? '0 : ref_mul(a, b);
        e.err  = timeout_mode;
        sb_q.push_back(e);
        bus.dst_ready = (hold == 0);

        @(negedge clk);
        k = 0;
        while (!bus.src_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.src_ready) check("src_ready_wait", 0, 1);
        bus.src_valid        = 1'b1;
        bus.src_multiplier   = a;
        bus.src_multiplicand = b;
        @(posedge clk);
        #1;
        bus.src_valid        = 1'b0;
        bus.src_multiplier   = $urandom;
        bus.src_multiplicand = $urandom;

        start_n = 0;
        c15_n   = 0;
        c15_k   = 0;
        kv      = 0;
        for (int c = 1; c <= 40 && kv == 0; c++) begin
            @(negedge clk);
            if (bus.dp_start_tx) start_n++;
            if (bus.dp_counted_15) begin
                c15_n++;
                c15_k = c;
            end
            if (bus.dst_valid) kv = c;
        end
        check("start_tx_cycles", start_n, WIDTH);
        check("counted_15_count", c15_n, 1);
        check("counted_15_step", c15_k, WIDTH);
        check("dst_valid_latency", kv, timeout_mode ? (WIDTH + 1 + TIMEOUT) : (WIDTH + 2));

        if (hold > 0) begin
            held     = bus.dst_product;
            unstable = 0;
            repeat (hold) begin
                @(negedge clk);
                if (bus.dst_product !== held || !bus.dst_valid || bus.src_ready) unstable++;
            end
            check("hold_stable", unstable, 0);
            @(posedge clk);
            #1;
            bus.dst_ready = 1'b1;
            @(posedge clk);
        end
        exp_ops++;
        @(negedge clk);
        check("post_src_ready", bus.src_ready, 1);
        check("post_dst_valid", bus.dst_valid, 0);
        check("op_count", op_count, CNT_W'(exp_ops));
    endtask

    initial begin
        tests                = 0;
        fails                = 0;
        exp_ops              = 0;
        dp_go_inject         = 1'b0;
        dp_mode_timeout      = 1'b0;
        reset                = 1'b1;
        bus.src_valid        = 1'b0;
        bus.src_multiplier   = '0;
        bus.src_multiplicand = '0;
        bus.dst_ready        = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_src_ready", bus.src_ready, 1);
        check("rst_start_tx", bus.dp_start_tx, 0);
        check("rst_counted_15", bus.dp_counted_15, 0);
        check("rst_multiplier", bus.dp_multiplier, 0);
        check("rst_multiplicand", bus.dp_multiplicand, 0);
        check("rst_dst_valid", bus.dst_valid, 0);
        check("rst_dst_product", bus.dst_product, 0);
        check("rst_dst_err", bus.dst_err, 0);
        check("rst_busy", busy, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op(16'd3, 16'd5, 1'b0, 0);
        run_op(16'hFFFE, 16'd3, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 0);
        run_op(16'($urandom), 16'($urandom), 1'b0, 10);
        run_op(16'd100, 16'd200, 1'b1, 0);
        check("timeout_no_seq_err", seq_err, 0);

        // Abort in the middle of RUN: outputs must fall back without a clock edge.
        dp_mode_timeout = 1'b0;
        @(negedge clk);
        bus.src_valid        = 1'b1;
        bus.src_multiplier   = 16'd11;
        bus.src_multiplicand = 16'd13;
        @(posedge clk);
        #1;
        bus.src_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_in_run", bus.dp_start_tx, 1);
        reset = 1'b1;
        #1;
        check("abort_start_tx", bus.dp_start_tx, 0);
        check("abort_busy", busy, 0);
        check("abort_src_ready", bus.src_ready, 1);
        check("abort_multiplier", bus.dp_multiplier, 0);
        check("abort_op_count", op_count, 0);
        exp_ops = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(16'd7, 16'd9, 1'b0, 0);

        @(negedge clk);
        dp_go_inject = 1'b1;
        @(negedge clk);
        dp_go_inject = 1'b0;
        check("seq_err_set", seq_err, 1);
        check("seq_err_idle_busy", busy, 0);
        @(negedge clk);
        check("seq_err_sticky", seq_err, 1);
        check("seq_err_idle_ready", bus.src_ready, 1);
        run_op(16'd2, 16'd2, 1'b0, 0);
        check("seq_err_still_set", seq_err, 1);

        for (int i = 0; i < 12; i++) begin
            run_op(16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
